// File: rtl/memory_req_master.sv
// Single-outstanding memory initiator: write strobes 1 cycle after accept, read response >= 2 cycles after the strobe.
// Response waits for rsp_ready while cmd_ready stays low; the MEMORY_MASTER_STATS_EN macro adds saturating statistics counters.
module memory_req_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  memory_clk,
  input  logic                  memory_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  memory_en,
  output logic                  memory_wr,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_data_in,
  input  logic                  memory_vld_out,
  input  logic [DATA_WIDTH-1:0] memory_data_out
`ifdef MEMORY_MASTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_wr_cnt,
  output logic [STAT_WIDTH-1:0] stat_rd_cnt,
  output logic [STAT_WIDTH-1:0] stat_timeout_cnt,
  output logic [STAT_WIDTH-1:0] stat_spurious_vld_cnt
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  memory_en_q, memory_en_d;
  logic                  memory_wr_q, memory_wr_d;
  logic [ADDR_WIDTH-1:0] memory_addr_q, memory_addr_d;
  logic [DATA_WIDTH-1:0] memory_data_in_q, memory_data_in_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  accept;
  logic                  timeout_hit;

  assign accept = (state_q == IDLE) && cmd_valid;
  // The counter is compared before its increment, so the error is raised on the
  // cycle the incremented count would reach TIMEOUT_CYCLES-1.
  assign timeout_hit = (state_q == READ_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

`ifdef MEMORY_MASTER_STATS_EN
  logic [STAT_WIDTH-1:0] stat_wr_q, stat_wr_d;
  logic [STAT_WIDTH-1:0] stat_rd_q, stat_rd_d;
  logic [STAT_WIDTH-1:0] stat_to_q, stat_to_d;
  logic [STAT_WIDTH-1:0] stat_sp_q, stat_sp_d;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + 1'b1 : v;
  endfunction
`endif

  always_ff @(posedge memory_clk or negedge memory_rst) begin
    if (!memory_rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      memory_en_q      <= 1'b0;
      memory_wr_q      <= 1'b0;
      memory_addr_q    <= '0;
      memory_data_in_q <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_err_q        <= 1'b0;
`ifdef MEMORY_MASTER_STATS_EN
      stat_wr_q        <= '0;
      stat_rd_q        <= '0;
      stat_to_q        <= '0;
      stat_sp_q        <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      memory_en_q      <= memory_en_d;
      memory_wr_q      <= memory_wr_d;
      memory_addr_q    <= memory_addr_d;
      memory_data_in_q <= memory_data_in_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_err_q        <= rsp_err_d;
`ifdef MEMORY_MASTER_STATS_EN
      stat_wr_q        <= stat_wr_d;
      stat_rd_q        <= stat_rd_d;
      stat_to_q        <= stat_to_d;
      stat_sp_q        <= stat_sp_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_valid) state_d = cmd_wr ? WRITE : READ_REQ;
      WRITE:     state_d = IDLE;
      READ_REQ:  state_d = READ_WAIT;
      READ_WAIT: if (memory_vld_out || timeout_hit) state_d = RESP;
      RESP:      if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    memory_en_d      = (state_d == WRITE) || (state_d == READ_REQ);
    memory_wr_d      = (state_d == WRITE);
    memory_addr_d    = accept ? cmd_addr : memory_addr_q;
    memory_data_in_d = (accept && cmd_wr) ? cmd_wdata : memory_data_in_q;
    cnt_d            = (state_q == READ_WAIT) ? cnt_q + 1'b1 : '0;
    rsp_valid_d      = (state_d == RESP);
    rsp_data_d       = rsp_data_q;
    rsp_err_d        = rsp_err_q;
    if (state_q == READ_WAIT) begin
      if (memory_vld_out) begin
        rsp_data_d = memory_data_out;
        rsp_err_d  = 1'b0;
      end else if (timeout_hit) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end
`ifdef MEMORY_MASTER_STATS_EN
    stat_wr_d = sat_inc(stat_wr_q, state_q == WRITE);
    stat_rd_d = sat_inc(stat_rd_q, state_q == READ_REQ);
    stat_to_d = sat_inc(stat_to_q, timeout_hit && !memory_vld_out);
    stat_sp_d = sat_inc(stat_sp_q, memory_vld_out && (state_q != READ_WAIT));
`endif
  end

  assign cmd_ready      = (state_q == IDLE);
  assign memory_en      = memory_en_q;
  assign memory_wr      = memory_wr_q;
  assign memory_addr    = memory_addr_q;
  assign memory_data_in = memory_data_in_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
`ifdef MEMORY_MASTER_STATS_EN
  assign stat_wr_cnt           = stat_wr_q;
  assign stat_rd_cnt           = stat_rd_q;
  assign stat_timeout_cnt      = stat_to_q;
  assign stat_spurious_vld_cnt = stat_sp_q;
`endif

endmodule

// File: tb/tb_memory_req_master.sv
// Directed bench for memory_req_master: vector table of writes/reads plus reset and stray-valid sequences.
module tb_memory_req_master;

  logic        memory_clk = 1'b0;
  logic        memory_rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        memory_en, memory_wr, memory_vld_out;
  logic [3:0]  memory_addr;
  logic [31:0] memory_data_in, memory_data_out;
`ifdef MEMORY_MASTER_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_timeout_cnt, stat_spurious_vld_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] last_wdata = 32'h0;

  always #5 memory_clk = ~memory_clk;

  memory_req_master #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16), .STAT_WIDTH(16)) dut (
    .memory_clk(memory_clk), .memory_rst(memory_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .memory_en(memory_en), .memory_wr(memory_wr), .memory_addr(memory_addr),
    .memory_data_in(memory_data_in), .memory_vld_out(memory_vld_out),
    .memory_data_out(memory_data_out)
`ifdef MEMORY_MASTER_STATS_EN
    ,
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
    .stat_timeout_cnt(stat_timeout_cnt), .stat_spurious_vld_cnt(stat_spurious_vld_cnt)
`endif
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;      // write data, or data returned by the memory for a read
    int          d;         // cycles after the read strobe that vld is driven, 0 = never
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;   // cycle of rsp_valid counted from the accept cycle
    int          hold;      // cycles rsp_ready is held low
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge memory_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.data;
    chk("accept_ready", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    chk("strobe_en", memory_en, 1);
    chk("strobe_wr", memory_wr, v.wr);
    chk("strobe_addr", memory_addr, v.addr);
    if (v.wr) begin
      chk("strobe_wdata", memory_data_in, v.data);
      chk("strobe_busy", cmd_ready, 0);
      last_wdata = v.data;
      tick;
      chk("wr_done_en", memory_en, 0);
      chk("wr_done_ready", cmd_ready, 1);
    end else begin
      chk("rd_data_in_held", memory_data_in, last_wdata);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        tick;
        memory_vld_out = 1'b0;
        if (rsp_valid) begin
          lat = k + 1;
          break;
        end
        chk("wait_en_low", memory_en, 0);
        if (k == v.d) begin
          memory_vld_out = 1'b1;
          memory_data_out = v.data;
        end
      end
      chk("rsp_latency", lat, v.exp_lat);
      for (int h = 0; h < v.hold; h++) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, v.exp_data);
        chk("hold_err", rsp_err, v.exp_err);
        chk("hold_no_accept", cmd_ready, 0);
        chk("hold_no_strobe", memory_en, 0);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd5; cmd_wdata = 32'h0BAD0BAD;
        tick;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("rsp_data", rsp_data, v.exp_data);
      chk("rsp_err", rsp_err, v.exp_err);
      chk("rsp_addr_kept", memory_addr, v.addr);
      tick;
      rsp_ready = 1'b0;
      chk("rsp_dropped", rsp_valid, 0);
      chk("rsp_idle_ready", cmd_ready, 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_en"}, memory_en, 0);
    chk({tag, "_wr"}, memory_wr, 0);
    chk({tag, "_addr"}, memory_addr, 0);
    chk({tag, "_data_in"}, memory_data_in, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic do_reset;
    memory_rst = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0; memory_vld_out = 1'b0;
    tick;
    memory_rst = 1'b1;
    last_wdata = 32'h0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 0,  32'h0,        1'b0, 0,  0};
    vecs[1] = '{1'b0, 4'd3,  32'hDEADBEEF, 1,  32'hDEADBEEF, 1'b0, 3,  4};
    vecs[2] = '{1'b0, 4'd7,  32'h12345678, 3,  32'h12345678, 1'b0, 5,  0};
    vecs[3] = '{1'b0, 4'd0,  32'h0,        0,  32'h0,        1'b1, 17, 1};
    vecs[4] = '{1'b0, 4'd15, 32'hA5A5A5A5, 15, 32'hA5A5A5A5, 1'b0, 17, 0};
    vecs[5] = '{1'b1, 4'd15, 32'hFFFFFFFF, 0,  32'h0,        1'b0, 0,  0};
    vecs[6] = '{1'b0, 4'd15, 32'hCAFEF00D, 2,  32'hCAFEF00D, 1'b0, 4,  2};

    memory_rst = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; memory_vld_out = 1'b0; memory_data_out = '0;

    // Reset held with random command traffic
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wr    = 1'($urandom_range(0, 1));
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_wdata = $urandom;
      tick;
      check_reset_vals("reset");
    end
    cmd_valid = 1'b0;
    memory_rst = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset pulse during READ_WAIT, then a late vld that must be ignored
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd6;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    chk("pre_reset_busy", cmd_ready, 0);
    memory_rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick;
    check_reset_vals("rst_edge");
    memory_rst = 1'b1;
    last_wdata = 32'h0;
    tick;
    memory_vld_out = 1'b1; memory_data_out = 32'h55555555;
    tick;
    memory_vld_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_vld_rsp_valid", rsp_valid, 0);
      chk("late_vld_rsp_data", rsp_data, 0);
      chk("late_vld_ready", cmd_ready, 1);
      tick;
    end

    // Read after the reset still works
    run_vec(vecs[2]);

`ifdef MEMORY_MASTER_STATS_EN
    do_reset;
    run_vec(vecs[0]);
    run_vec(vecs[1]);
    run_vec(vecs[5]);
    run_vec(vecs[3]);
    run_vec(vecs[0]);
    memory_vld_out = 1'b1; memory_data_out = 32'h77777777;
    tick;
    memory_vld_out = 1'b0;
    tick;
    chk("stat_wr", stat_wr_cnt, 3);
    chk("stat_rd", stat_rd_cnt, 2);
    chk("stat_timeout", stat_timeout_cnt, 1);
    chk("stat_spurious", stat_spurious_vld_cnt, 1);
`else
    do_reset;
    check_reset_vals("final_reset");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
